// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM states and memory geometry.
package mem_copy_engine_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned MEM_WORDS  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_WRITE,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Control handshake plus memory bus of the copy engine.
// master = the engine (bus initiator), slave = control path and memory.
interface mem_copy_engine_if #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 6
);

    logic                   start;
    logic [ADDR_WIDTH-1:0]  src_addr;
    logic [ADDR_WIDTH-1:0]  dst_addr;
    logic [COUNT_WIDTH-1:0] word_count;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [ADDR_WIDTH-1:0]  address;
    logic                   MemRead;
    logic                   MemWrite;
    logic [DATA_WIDTH-1:0]  WriteData;
    logic [DATA_WIDTH-1:0]  ReadData;

    modport master (
        input  start, src_addr, dst_addr, word_count, ReadData,
        output busy, done, error, address, MemRead, MemWrite, WriteData
    );

    modport slave (
        output start, src_addr, dst_addr, word_count, ReadData,
        input  busy, done, error, address, MemRead, MemWrite, WriteData
    );

endinterface

// File: rtl/mem_copy_engine.sv
// Forward word-by-word block copy between two regions of data memory.
// Every output is a flop loaded with the value for the state being entered,
// so strobes/pulses line up with the state they belong to.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    mem_copy_engine_if.master bus
);

    // One extra bit over the count so word index + count can never wrap.
    localparam int SUM_W = COUNT_WIDTH + 1;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0]  dst_ptr_q, dst_ptr_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ADDR_WIDTH-1:0]  address_q, address_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;

    logic [SUM_W-1:0]       src_end, dst_end;
    logic                   misaligned, out_of_range;

    // Request validation: word alignment and end-of-block within memory.
    always_comb begin
        src_end      = SUM_W'(src_ptr_q[ADDR_WIDTH-1:2]) + SUM_W'(remaining_q);
        dst_end      = SUM_W'(dst_ptr_q[ADDR_WIDTH-1:2]) + SUM_W'(remaining_q);
        misaligned   = (src_ptr_q[1:0] != 2'b00) || (dst_ptr_q[1:0] != 2'b00);
        out_of_range = (src_end > SUM_W'(MEM_WORDS)) || (dst_end > SUM_W'(MEM_WORDS));
    end

    // Next state plus next registered output values.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        address_d   = address_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    src_ptr_d   = bus.src_addr;
                    dst_ptr_d   = bus.dst_addr;
                    remaining_d = bus.word_count;
                    busy_d      = 1'b1;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (misaligned || out_of_range) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (remaining_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    mem_read_d = 1'b1;
                    address_d  = src_ptr_q;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                // The captured word is also the registered WriteData of the next cycle.
                data_d      = bus.ReadData;
                mem_write_d = 1'b1;
                address_d   = dst_ptr_q;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                src_ptr_d   = src_ptr_q + ADDR_WIDTH'(WORD_BYTES);
                dst_ptr_d   = dst_ptr_q + ADDR_WIDTH'(WORD_BYTES);
                remaining_d = remaining_q - COUNT_WIDTH'(1);
                if (remaining_q == COUNT_WIDTH'(1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FINISH;
                end else begin
                    mem_read_d = 1'b1;
                    address_d  = src_ptr_q + ADDR_WIDTH'(WORD_BYTES);
                    state_d    = ST_READ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            address_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            address_q   <= address_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.address   = address_q;
    assign bus.MemRead   = mem_read_q;
    assign bus.MemWrite  = mem_write_q;
    assign bus.WriteData = data_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed and randomized copy requests against a word-array model of memory.
module tb_mem_copy_engine;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int CW = 6;

    logic clock;
    logic reset;

    mem_copy_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus_if ();

    mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory: combinational read, write at the clock edge; preload port for setup.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] ref_mem [32];
    logic          pl_we;
    logic [4:0]    pl_idx;
    logic [DW-1:0] pl_data;

    assign bus_if.ReadData = mem[bus_if.address[AW-1:2]];

    always @(posedge clock) begin
        if (bus_if.MemWrite) mem[bus_if.address[AW-1:2]] <= bus_if.WriteData;
        else if (pl_we) mem[pl_idx] <= pl_data;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Bus monitor, sampled on the falling edge.
    int rd_tot = 0, wr_tot = 0, both_tot = 0, stray_tot = 0;
    int busy_tot = 0, done_tot = 0, err_tot = 0, evt_cyc = 0;
    always @(negedge clock) begin
        if (bus_if.MemRead) rd_tot <= rd_tot + 1;
        if (bus_if.MemWrite) wr_tot <= wr_tot + 1;
        if (bus_if.MemRead && bus_if.MemWrite) both_tot <= both_tot + 1;
        if (!bus_if.busy && (bus_if.MemRead || bus_if.MemWrite)) stray_tot <= stray_tot + 1;
        if (bus_if.busy) busy_tot <= busy_tot + 1;
        if (bus_if.done) done_tot <= done_tot + 1;
        if (bus_if.error) err_tot <= err_tot + 1;
        if (bus_if.done || bus_if.error) evt_cyc <= cyc;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // One request; kill_at_write>0 resets during that WRITE, restart_at>0 pulses
    // a second start that many cycles after the first one.
    task automatic run_copy(input string name, input int src, input int dst, input int cnt,
                            input int kill_at_write, input int restart_at);
        int b_rd, b_wr, b_both, b_stray, b_busy, b_done, b_err, s_cyc, nw, exp_lat;
        bit valid, finished;

        tick();
        b_rd = rd_tot; b_wr = wr_tot; b_both = both_tot; b_stray = stray_tot;
        b_busy = busy_tot; b_done = done_tot; b_err = err_tot;
        bus_if.src_addr   = AW'(src);
        bus_if.dst_addr   = AW'(dst);
        bus_if.word_count = CW'(cnt);
        bus_if.start      = 1'b1;
        s_cyc             = cyc;
        finished          = 1'b0;

        for (int k = 0; k < 300; k++) begin
            tick();
            if (k + 1 == restart_at) begin
                bus_if.start      = 1'b1;
                bus_if.src_addr   = AW'(0);
                bus_if.dst_addr   = AW'(4);
                bus_if.word_count = CW'(1);
            end else begin
                bus_if.start = 1'b0;
            end
            if (kill_at_write > 0 && bus_if.MemWrite && (wr_tot - b_wr) == kill_at_write) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check({name, ".kill_strobes"}, {30'd0, bus_if.MemRead, bus_if.MemWrite}, 32'd0);
                check({name, ".kill_busy"}, {31'd0, bus_if.busy}, 32'd0);
                finished = 1'b1;
                break;
            end
            if ((done_tot - b_done) + (err_tot - b_err) > 0) begin
                finished = 1'b1;
                break;
            end
        end
        bus_if.start = 1'b0;
        check({name, ".finished"}, {31'd0, finished}, 32'd1);
        exp_lat = 0;

        valid = (src % 4 == 0) && (dst % 4 == 0) && (src / 4 + cnt <= 32) && (dst / 4 + cnt <= 32);
        if (kill_at_write == 0) begin
            exp_lat = valid ? 2 * cnt + 2 : 2;
            check({name, ".latency"}, 32'(evt_cyc - s_cyc), 32'(exp_lat));
        end

        repeat (10) tick();

        nw = (kill_at_write > 0) ? kill_at_write : (valid ? cnt : 0);
        check({name, ".done_cnt"}, 32'(done_tot - b_done), (kill_at_write == 0 && valid) ? 32'd1 : 32'd0);
        check({name, ".err_cnt"}, 32'(err_tot - b_err), (kill_at_write == 0 && !valid) ? 32'd1 : 32'd0);
        check({name, ".reads"}, 32'(rd_tot - b_rd), 32'(nw));
        check({name, ".writes"}, 32'(wr_tot - b_wr), 32'(nw));
        check({name, ".rw_overlap"}, 32'(both_tot - b_both), 32'd0);
        check({name, ".stray_strobe"}, 32'(stray_tot - b_stray), 32'd0);
        check({name, ".busy_cycles"}, 32'(busy_tot - b_busy),
              (kill_at_write > 0) ? 32'(2 * kill_at_write + 1) : 32'(exp_lat - 1));

        for (int i = 0; i < nw; i++) ref_mem[dst / 4 + i] = ref_mem[src / 4 + i];
        for (int i = 0; i < 32; i++) check($sformatf("%s.mem%0d", name, i), mem[i], ref_mem[i]);
    endtask

    initial begin
        int rs, rd, rc;
        reset             = 1'b1;
        pl_we             = 1'b0;
        pl_idx            = '0;
        pl_data           = '0;
        bus_if.start      = 1'b0;
        bus_if.src_addr   = '0;
        bus_if.dst_addr   = '0;
        bus_if.word_count = '0;

        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = (i == 0) ? 32'd1000 : (i == 1) ? 32'd200 : (i == 2) ? 32'd300 :
                         (i == 3) ? 32'd400 : $urandom;
            pl_we   = 1'b1;
            pl_idx  = 5'(i);
            pl_data = ref_mem[i];
            tick();
        end
        pl_we = 1'b0;

        check("rst.busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst.done", {31'd0, bus_if.done}, 32'd0);
        check("rst.error", {31'd0, bus_if.error}, 32'd0);
        check("rst.address", {25'd0, bus_if.address}, 32'd0);
        check("rst.MemRead", {31'd0, bus_if.MemRead}, 32'd0);
        check("rst.MemWrite", {31'd0, bus_if.MemWrite}, 32'd0);
        check("rst.WriteData", bus_if.WriteData, 32'd0);
        reset = 1'b0;
        tick();

        run_copy("t1_basic", 0, 64, 4, 0, 0);
        check("t1.word16", mem[16], 32'd1000);
        check("t1.word19", mem[19], 32'd400);
        run_copy("t2_misaligned", 2, 64, 1, 0, 0);
        run_copy("t3_range_over", 120, 0, 3, 0, 0);
        run_copy("t3_last_word", 116, 0, 3, 0, 0);
        run_copy("t3_dst_edge", 0, 124, 1, 0, 0);
        run_copy("t4_zero", 8, 12, 0, 0, 0);
        run_copy("t5_reset_mid", 0, 32, 5, 3, 0);
        run_copy("t5_after_reset", 4, 100, 5, 0, 0);
        run_copy("t6_restart_busy", 16, 80, 4, 0, 3);
        run_copy("t6_restart_finish", 4, 40, 3, 0, 8);
        run_copy("ovl_dst_above", 0, 8, 6, 0, 0);
        run_copy("ovl_dst_below", 20, 8, 6, 0, 0);
        run_copy("cnt_too_big", 0, 0, 33, 0, 0);

        for (int r = 0; r < 14; r++) begin
            rs = $urandom_range(0, 31) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            rd = $urandom_range(0, 31) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            rc = $urandom_range(0, 10);
            run_copy($sformatf("rand%0d", r), rs, rd, rc, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
